noc_network_interface: RTL and testbench

//  Per-node network interface between a core and its mesh-router local port.
//  TX: accepts core send requests (dest node id + payload), builds flits, buffers them, and presents them to the router under backpressure.
//  RX: captures flits delivered by the router, buffers them for the core, and drives the node availability signal.

---
 rtl/noc_ni_pkg.sv | 28 ++
 rtl/noc_ni_fifo.sv | 58 +++++
 rtl/noc_network_interface.sv | 106 ++++++++++
 tb/tb_noc_network_interface.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_ni_pkg.sv
// Shared flit layout constants and node-id helpers for the mesh network interface.
package noc_ni_pkg;

    localparam int COORD_W = 2;
    localparam int ID_W    = 4;
    localparam int HDR_W   = 1 + 2 * COORD_W + ID_W;

    // Header bits sitting above the payload in every flit.
    typedef struct packed {
        logic               valid;
        logic [COORD_W-1:0] dst_y;
        logic [COORD_W-1:0] dst_x;
        logic [ID_W-1:0]    src;
    } flit_hdr_t;

    // Row-major id to {y, x}; with a constant cols this folds into constant-divisor logic.
    function automatic logic [2*COORD_W-1:0] node_id_to_xy(input logic [ID_W-1:0] id,
                                                           input int unsigned cols);
        int unsigned idn;
        int unsigned xn;
        int unsigned yn;
        idn = 32'(id);
        xn  = idn % cols;
        yn  = idn / cols;
        return {yn[COORD_W-1:0], xn[COORD_W-1:0]};
    endfunction

endpackage

// File: rtl/noc_ni_fifo.sv
// Synchronous FIFO with wrap-bit pointers, registered full/empty and a combinational head.
module noc_ni_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic             do_push, do_pop;

    // Guards use registered flags only, so a pop while full never frees a slot the same cycle.
    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    always_comb begin
        wr_d    = wr_q + {{AW{1'b0}}, do_push};
        rd_d    = rd_q + {{AW{1'b0}}, do_pop};
        empty_d = (wr_d == rd_d);
        full_d  = (wr_d == {~rd_d[AW], rd_d[AW-1:0]});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= data_i;
        end
    end

    assign head_o  = mem_q[rd_q[AW-1:0]];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/noc_network_interface.sv
// Per-node NI: builds and buffers TX flits for the router, buffers RX flits for the core,
// and keeps saturating counts of RX overflow drops and misrouted arrivals.
module noc_network_interface
    import noc_ni_pkg::*;
#(
    parameter  int NODE_ID   = 0,
    parameter  int X         = 3,
    parameter  int Y         = 3,
    parameter  int PAYLOAD_W = 16,
    parameter  int DEPTH     = 4,
    localparam int FLIT_W    = HDR_W + PAYLOAD_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [ID_W-1:0]      tx_dest,
    input  logic [PAYLOAD_W-1:0] tx_payload,
    output logic [FLIT_W-1:0]    flit_out,
    input  logic                 noc_ready,
    input  logic [FLIT_W-1:0]    flit_in,
    output logic                 node_avail,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [ID_W-1:0]      rx_src,
    output logic [PAYLOAD_W-1:0] rx_payload,
    output logic [7:0]           drop_cnt,
    output logic [7:0]           misroute_cnt
);

    localparam int                   NODES = X * Y;
    localparam logic [2*COORD_W-1:0] MY_XY = node_id_to_xy(ID_W'(NODE_ID), X);

    // TX path: the valid bit is implied by FIFO occupancy, so it is not stored.
    logic                 tx_full, tx_empty, tx_push;
    logic [FLIT_W-2:0]    tx_data, tx_head;

    assign tx_push = tx_valid && !tx_full && (32'(tx_dest) < 32'(NODES));
    assign tx_data = {node_id_to_xy(tx_dest, X), ID_W'(NODE_ID), tx_payload};

    noc_ni_fifo #(.WIDTH(FLIT_W - 1), .DEPTH(DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (tx_push),
        .data_i  (tx_data),
        .pop_i   (noc_ready),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .head_o  (tx_head)
    );

    assign tx_ready = !tx_full;
    assign flit_out = tx_empty ? '0 : {1'b1, tx_head};

    // RX path: only src and payload are kept; the destination is consumed by the misroute check.
    flit_hdr_t                 rx_hdr;
    logic                      rx_full, rx_empty, rx_drop, rx_misroute;
    logic [ID_W+PAYLOAD_W-1:0] rx_data, rx_head;

    assign rx_hdr      = flit_in[FLIT_W-1 -: HDR_W];
    assign rx_data     = {rx_hdr.src, flit_in[PAYLOAD_W-1:0]};
    assign rx_drop     = rx_hdr.valid && rx_full;
    assign rx_misroute = rx_hdr.valid && ({rx_hdr.dst_y, rx_hdr.dst_x} != MY_XY);

    noc_ni_fifo #(.WIDTH(ID_W + PAYLOAD_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rx_hdr.valid),
        .data_i  (rx_data),
        .pop_i   (rx_ready),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .head_o  (rx_head)
    );

    assign node_avail           = !rx_full;
    assign rx_valid             = !rx_empty;
    assign {rx_src, rx_payload} = rx_empty ? '0 : rx_head;

    logic [7:0] drop_q, drop_d, mis_q, mis_d;

    always_comb begin
        drop_d = drop_q;
        mis_d  = mis_q;
        if (rx_drop && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
        if (rx_misroute && (mis_q != 8'hFF)) begin
            mis_d = mis_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
            mis_q  <= '0;
        end else begin
            drop_q <= drop_d;
            mis_q  <= mis_d;
        end
    end

    assign drop_cnt     = drop_q;
    assign misroute_cnt = mis_q;

endmodule

// File: tb/tb_noc_network_interface.sv
// Directed bench for noc_network_interface with a queue-based reference model checked every cycle.
module tb_noc_network_interface;

    localparam int NODE_ID   = 4;
    localparam int X         = 3;
    localparam int Y         = 3;
    localparam int PAYLOAD_W = 16;
    localparam int DEPTH     = 4;
    localparam int FLIT_W    = 9 + PAYLOAD_W;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [3:0]           tx_dest;
    logic [PAYLOAD_W-1:0] tx_payload;
    logic [FLIT_W-1:0]    flit_out;
    logic                 noc_ready;
    logic [FLIT_W-1:0]    flit_in;
    logic                 node_avail;
    logic                 rx_valid;
    logic                 rx_ready;
    logic [3:0]           rx_src;
    logic [PAYLOAD_W-1:0] rx_payload;
    logic [7:0]           drop_cnt;
    logic [7:0]           misroute_cnt;

    noc_network_interface #(
        .NODE_ID(NODE_ID), .X(X), .Y(Y), .PAYLOAD_W(PAYLOAD_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dest(tx_dest), .tx_payload(tx_payload),
        .flit_out(flit_out), .noc_ready(noc_ready), .flit_in(flit_in),
        .node_avail(node_avail), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_src(rx_src), .rx_payload(rx_payload),
        .drop_cnt(drop_cnt), .misroute_cnt(misroute_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [FLIT_W-1:0] mk_flit(input int dy, input int dx, input int src,
                                                  input logic [15:0] pl);
        return {1'b1, 2'(dy), 2'(dx), 4'(src), pl};
    endfunction

    // Reference model: plain queues of what is buffered, updated on each rising edge.
    logic [FLIT_W-1:0] m_tx_q[$];
    logic [19:0]       m_rx_q[$];
    int                m_drop = 0;
    int                m_mis  = 0;
    bit                m_live = 0;
    int                m_txn, m_rxn, m_dx, m_dy;

    always @(posedge clk) begin
        if (rst) begin
            m_tx_q.delete();
            m_rx_q.delete();
            m_drop = 0;
            m_mis  = 0;
            m_live = 1;
        end else begin
            m_txn = m_tx_q.size();
            m_rxn = m_rx_q.size();
            if (noc_ready && m_txn > 0) void'(m_tx_q.pop_front());
            if (tx_valid && m_txn < DEPTH && int'(tx_dest) < X * Y)
                m_tx_q.push_back(mk_flit(int'(tx_dest) / X, int'(tx_dest) % X, NODE_ID, tx_payload));
            if (rx_ready && m_rxn > 0) void'(m_rx_q.pop_front());
            if (flit_in[FLIT_W-1]) begin
                m_dy = int'(flit_in[23:22]);
                m_dx = int'(flit_in[21:20]);
                if (m_dy * X + m_dx != NODE_ID && m_mis < 255) m_mis++;
                if (m_rxn == DEPTH) begin
                    if (m_drop < 255) m_drop++;
                end else begin
                    m_rx_q.push_back(flit_in[19:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("m_tx_ready", 32'(tx_ready), 32'(m_tx_q.size() < DEPTH));
            check("m_flit_out", 32'(flit_out), m_tx_q.size() > 0 ? 32'(m_tx_q[0]) : 32'd0);
            check("m_node_avail", 32'(node_avail), 32'(m_rx_q.size() < DEPTH));
            check("m_rx_valid", 32'(rx_valid), 32'(m_rx_q.size() > 0));
            check("m_rx_head", 32'({rx_src, rx_payload}), m_rx_q.size() > 0 ? 32'(m_rx_q[0]) : 32'd0);
            check("m_drop_cnt", 32'(drop_cnt), 32'(m_drop));
            check("m_misroute_cnt", 32'(misroute_cnt), 32'(m_mis));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    logic [FLIT_W-1:0] exp_tx [4];

    initial begin
        exp_tx[0] = 25'h1040001;
        exp_tx[1] = 25'h1140002;
        exp_tx[2] = 25'h1240003;
        exp_tx[3] = 25'h1440004;

        rst = 1'b1; tx_valid = 0; tx_dest = 0; tx_payload = 0;
        noc_ready = 0; flit_in = 0; rx_ready = 0;
        cyc(); cyc();
        rst = 1'b0;
        check("reset_tx_ready", 32'(tx_ready), 32'd1);
        check("reset_flit_out", 32'(flit_out), 32'd0);
        check("reset_node_avail", 32'(node_avail), 32'd1);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_counters", 32'({drop_cnt, misroute_cnt}), 32'd0);

        // Single send, consumed immediately by the router.
        noc_ready = 1; tx_valid = 1; tx_dest = 8; tx_payload = 16'hBEEF;
        $display("tx dest=%0d payload=%h", tx_dest, tx_payload);
        cyc();
        tx_valid = 0;
        check("t1_flit", 32'(flit_out), 32'h1A4BEEF);
        cyc();
        check("t1_flit_gone", 32'(flit_out), 32'd0);

        // Backpressure: fifth send is refused, then drain in order.
        noc_ready = 0;
        for (int i = 0; i < 5; i++) begin
            tx_valid = 1; tx_dest = 4'(i); tx_payload = 16'(i + 1);
            $display("tx dest=%0d payload=%h ready=%0d", tx_dest, tx_payload, tx_ready);
            cyc();
            if (i == 3) check("t2_full_tx_ready", 32'(tx_ready), 32'd0);
        end
        tx_valid = 0; noc_ready = 1;
        for (int i = 0; i < 4; i++) begin
            check("t2_drain_flit", 32'(flit_out), 32'(exp_tx[i]));
            cyc();
        end
        check("t2_drained_flit", 32'(flit_out), 32'd0);
        check("t2_drained_ready", 32'(tx_ready), 32'd1);

        // Out-of-range destination is swallowed.
        check("t5_oob_accept", 32'(tx_ready), 32'd1);
        tx_valid = 1; tx_dest = 9; tx_payload = 16'h1234;
        $display("tx dest=%0d payload=%h", tx_dest, tx_payload);
        cyc();
        tx_valid = 0;
        check("t5_oob_flit", 32'(flit_out), 32'd0);
        cyc();
        check("t5_oob_flit2", 32'(flit_out), 32'd0);

        // RX overflow: four queued, fifth dropped.
        for (int i = 0; i < 5; i++) begin
            flit_in = mk_flit(1, 1, 2, 16'hA000 + 16'(i));
            $display("rx flit=%h", flit_in);
            cyc();
            if (i == 3) check("t3_node_avail", 32'(node_avail), 32'd0);
        end
        flit_in = 0;
        check("t3_drop_cnt", 32'(drop_cnt), 32'd1);
        check("t3_no_misroute", 32'(misroute_cnt), 32'd0);
        rx_ready = 1;
        for (int i = 0; i < 4; i++) begin
            check("t3_pop_valid", 32'(rx_valid), 32'd1);
            check("t3_pop_payload", 32'(rx_payload), 32'hA000 + 32'(i));
            check("t3_pop_src", 32'(rx_src), 32'd2);
            cyc();
        end
        rx_ready = 0;
        check("t3_empty", 32'(rx_valid), 32'd0);
        check("t3_avail", 32'(node_avail), 32'd1);

        // Misrouted flit is counted and still delivered.
        flit_in = mk_flit(0, 0, 7, 16'h5A5A);
        $display("rx flit=%h", flit_in);
        cyc();
        flit_in = 0;
        check("t4_mis_cnt", 32'(misroute_cnt), 32'd1);
        check("t4_rx_valid", 32'(rx_valid), 32'd1);
        check("t4_rx_payload", 32'(rx_payload), 32'h5A5A);
        check("t4_rx_src", 32'(rx_src), 32'd7);
        rx_ready = 1;
        cyc();
        for (int i = 0; i < 300; i++) begin
            flit_in = mk_flit(0, 0, 3, 16'(i));
            cyc();
        end
        $display("rx 300 misrouted flits streamed");
        flit_in = 0;
        cyc();
        rx_ready = 0;
        check("t4_mis_sat", 32'(misroute_cnt), 32'd255);
        check("t4_drop_keep", 32'(drop_cnt), 32'd1);
        check("t4_drained", 32'(rx_valid), 32'd0);

        // Simultaneous push and pop on a partly filled RX FIFO.
        flit_in = mk_flit(1, 1, 1, 16'hB001); cyc();
        flit_in = mk_flit(1, 1, 1, 16'hB002); cyc();
        flit_in = mk_flit(1, 1, 1, 16'hB003); rx_ready = 1;
        $display("rx flit=%h with pop", flit_in);
        cyc();
        flit_in = 0;
        check("t5_pp_head", 32'(rx_payload), 32'hB002);
        cyc();
        check("t5_pp_second", 32'(rx_payload), 32'hB003);
        cyc();
        rx_ready = 0;
        check("t5_pp_empty", 32'(rx_valid), 32'd0);

        // Reset while both FIFOs are full.
        noc_ready = 0;
        for (int i = 0; i < 4; i++) begin
            tx_valid = 1; tx_dest = 5; tx_payload = 16'hC000 + 16'(i);
            flit_in = mk_flit(1, 1, 1, 16'hD000 + 16'(i));
            cyc();
        end
        tx_valid = 0; flit_in = 0;
        check("t6_tx_full", 32'(tx_ready), 32'd0);
        check("t6_rx_full", 32'(node_avail), 32'd0);
        rst = 1;
        cyc();
        check("t6_flit_out", 32'(flit_out), 32'd0);
        check("t6_node_avail", 32'(node_avail), 32'd1);
        check("t6_tx_ready", 32'(tx_ready), 32'd1);
        check("t6_counters", 32'({drop_cnt, misroute_cnt}), 32'd0);
        check("t6_rx_valid", 32'(rx_valid), 32'd0);
        rst = 0;
        cyc(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
